// File: rtl/picoram_mem_arbiter_pkg.sv
// Shared definitions for the two-requester PicoRAM arbiter: FSM encoding,
// requester indices and a small decode helper.
package picoram_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;
    localparam int   N_REQ  = 2;

    // A request with no byte enables is a read.
    function automatic logic is_read(input logic [3:0] wstrb);
        return (wstrb == 4'h0);
    endfunction

endpackage

// File: rtl/picoram_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a contended
// request goes to whichever requester was not granted last time.
module picoram_rr_arb2
    import picoram_mem_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_last_grant,
    output logic             o_grant_valid,
    output logic             o_grant_idx
);

    always_comb begin
        o_grant_valid = |i_valid;
        o_grant_idx   = REQ_M0;
        if (&i_valid) begin
            o_grant_idx = ~i_last_grant;
        end else if (i_valid[REQ_M1]) begin
            o_grant_idx = REQ_M1;
        end
    end

endmodule

// File: rtl/picoram_mem_arbiter.sv
// Arbitrates two simple valid/ready requesters onto one single-port SRAM
// with a registered read port; one access every three cycles.
//
// state  | meaning
// IDLE   | waiting for a request; grant and request fields latched on exit
// ACCESS | SRAM strobe driven for the granted request (gated by window check)
// RESP   | one-cycle ready pulse to the granted requester with read data
module picoram_mem_arbiter
    import picoram_mem_arbiter_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          AW        = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          m0_valid,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_ready,
    output logic [31:0]   m0_rdata,

    input  logic          m1_valid,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_ready,
    output logic [31:0]   m1_rdata,

    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_grant;
    logic          r_last_grant;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_in_win;

    logic          w_grant_valid;
    logic          w_grant_idx;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_sel_wstrb;
    logic [31:0]   w_offset;
    logic          w_in_win;
    logic [31:0]   w_resp_data;

    picoram_rr_arb2 u_rr_arb2 (
        .i_valid       ({m1_valid, m0_valid}),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_sel_addr  = (w_grant_idx == REQ_M1) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_grant_idx == REQ_M1) ? m1_wdata : m0_wdata;
    assign w_sel_wstrb = (w_grant_idx == REQ_M1) ? m1_wstrb : m0_wstrb;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the window test.
    assign w_offset = w_sel_addr - BASE_ADDR;
    assign w_in_win = ({1'b0, w_offset} < WIN_BYTES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= REQ_M0;
            r_last_grant <= REQ_M1;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_in_win     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Request fields are captured so a requester misbehaving after
            // the grant cannot corrupt the access already in flight.
            if (r_state == ST_IDLE && w_grant_valid) begin
                r_grant  <= w_grant_idx;
                r_waddr  <= w_offset[AW+1:2];
                r_wdata  <= w_sel_wdata;
                r_wstrb  <= w_sel_wstrb;
                r_in_win <= w_in_win;
            end
            if (r_state == ST_RESP) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 4'h0;
        mem_addr    = r_waddr;
        mem_wdata   = r_wdata;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = 32'h0;
        m1_rdata    = 32'h0;
        w_resp_data = 32'h0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en      = r_in_win;
                mem_we      = r_in_win ? r_wstrb : 4'h0;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (is_read(r_wstrb) && r_in_win) begin
                    w_resp_data = mem_rdata;
                end
                if (r_grant == REQ_M1) begin
                    m1_ready = 1'b1;
                    m1_rdata = w_resp_data;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = w_resp_data;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_picoram_mem_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_picoram_mem_arbiter;

    localparam int          MEM_WORDS = 1024;
    localparam int          AW        = 10;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          m0_valid, m1_valid;
    logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic          m0_ready, m1_ready;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    picoram_mem_arbiter #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0_valid  (m0_valid),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0F00;
    endfunction

    // SRAM with registered read port, preloaded on the first clock edge.
    logic [31:0] sram [MEM_WORDS];
    logic        sram_ready = 1'b0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_word(i);
            sram_ready <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= sram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction is granted at a sampling edge, its SRAM
    // strobe is visible one cycle later, its response the cycle after that,
    // followed by one idle cycle before the next grant can be taken.
    logic [31:0] ref_mem [MEM_WORDS];
    int          age;
    int          last;
    int          cur_idx;
    logic [31:0] cur_addr, cur_wdata, cur_resp;
    logic [3:0]  cur_wstrb;

    logic          exp_en;
    logic [3:0]    exp_we;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;
    logic          exp_rdy0, exp_rdy1;
    logic [31:0]   exp_rd0, exp_rd1;

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned lo, hi, x;
        lo = 64'(BASE);
        hi = lo + 64'(4 * MEM_WORDS);
        x  = 64'(a);
        return (x >= lo) && (x < hi);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'(MEM_WORDS - 1));
    endfunction

    task automatic clear_exp();
        exp_en = 1'b0; exp_we = 4'h0; exp_addr = '0; exp_wdata = '0;
        exp_rdy0 = 1'b0; exp_rdy1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
    endtask

    task automatic model_step();
        int w;
        clear_exp();
        if (!reset_n) begin
            age = -1;
            last = 1;
        end else if (age == 1) begin
            age = 2;
            cur_resp = 32'h0;
            if (in_win(cur_addr)) begin
                w = word_of(cur_addr);
                if (cur_wstrb == 4'h0) cur_resp = ref_mem[w];
                for (int b = 0; b < 4; b++)
                    if (cur_wstrb[b]) ref_mem[w][8*b +: 8] = cur_wdata[8*b +: 8];
            end
        end else if (age == 2) begin
            last = cur_idx;
            age = -1;
        end else if (m0_valid || m1_valid) begin
            if (m0_valid && m1_valid) cur_idx = 1 - last;
            else cur_idx = m0_valid ? 0 : 1;
            cur_addr  = (cur_idx == 1) ? m1_addr  : m0_addr;
            cur_wdata = (cur_idx == 1) ? m1_wdata : m0_wdata;
            cur_wstrb = (cur_idx == 1) ? m1_wstrb : m0_wstrb;
            age = 1;
        end
        if (age == 1) begin
            exp_en    = in_win(cur_addr);
            exp_addr  = AW'(word_of(cur_addr));
            exp_we    = exp_en ? cur_wstrb : 4'h0;
            exp_wdata = cur_wdata;
        end else if (age == 2) begin
            if (cur_idx == 1) begin exp_rdy1 = 1'b1; exp_rd1 = cur_resp; end
            else begin exp_rdy0 = 1'b1; exp_rd0 = cur_resp; end
        end
    endtask

    task automatic compare();
        check("mem_en", 32'(mem_en), 32'(exp_en));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_en) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_en && exp_we != 4'h0) check("mem_wdata", mem_wdata, exp_wdata);
        check("m0_ready", 32'(m0_ready), 32'(exp_rdy0));
        check("m1_ready", 32'(m1_ready), 32'(exp_rdy1));
        check("m0_rdata", m0_rdata, exp_rd0);
        check("m1_rdata", m1_rdata, exp_rd1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        #1;
        age = -1;
        last = 1;
        clear_exp();
        compare();
    endtask

    bit pend [2];

    task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (n == 1) begin m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
        else begin m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
        pend[n] = 1'b1;
    endtask

    task automatic clr(input int n);
        if (n == 1) m1_valid = 1'b0; else m0_valid = 1'b0;
        pend[n] = 1'b0;
    endtask

    task automatic new_rand_req(input int n);
        logic [31:0] a;
        logic [3:0]  s;
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) a = 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 63));
        else if (r == 1) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        else a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        set_req(n, a, $urandom, s);
    endtask

    task automatic random_drive();
        logic rdy;
        for (int n = 0; n < 2; n++) begin
            rdy = (n == 1) ? m1_ready : m0_ready;
            if (pend[n]) begin
                if (rdy) begin
                    if ($urandom_range(0, 3) == 0) new_rand_req(n);
                    else clr(n);
                end else if ($urandom_range(0, 299) == 0) begin
                    clr(n);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_rand_req(n);
            end
        end
    endtask

    int t0;
    int cnt;
    int order [$];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        pend[0] = 0; pend[1] = 0;
        age = -1; last = 1; cur_idx = 0;
        cur_addr = 0; cur_wdata = 0; cur_wstrb = 0; cur_resp = 0;
        clear_exp();
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_m0_ready", 32'(m0_ready), 0);
        check("rst_m1_ready", 32'(m1_ready), 0);
        check("rst_mem_en", 32'(mem_en), 0);

        // Contention straight out of reset: m0 first, m1 three cycles later.
        reset_n = 1'b1;
        set_req(0, 32'h40, 0, 4'h0);
        set_req(1, 32'h44, 0, 4'h0);
        tick();
        check("c1_acc_en", 32'(mem_en), 1);
        check("c1_acc_addr", 32'(mem_addr), 16);
        tick();
        check("c1_m0_ready", 32'(m0_ready), 1);
        check("c1_m1_idle", 32'(m1_ready), 0);
        check("c1_m0_rdata", m0_rdata, init_word(16));
        t0 = cyc;
        clr(0);
        tick(); tick();
        check("c1_acc2_addr", 32'(mem_addr), 17);
        tick();
        check("c1_m1_ready", 32'(m1_ready), 1);
        check("c1_m1_rdata", m1_rdata, init_word(17));
        check("c1_m1_delay", 32'(cyc - t0), 3);
        clr(1);
        tick();
        set_req(0, 32'h48, 0, 4'h0);
        set_req(1, 32'h4C, 0, 4'h0);
        tick();
        check("c2_acc_addr", 32'(mem_addr), 18);
        tick();
        check("c2_m0_ready", 32'(m0_ready), 1);
        clr(0);
        tick(); tick(); tick();
        check("c2_m1_ready", 32'(m1_ready), 1);
        clr(1);
        tick();

        // Full-word write.
        set_req(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        tick();
        check("w_en", 32'(mem_en), 1);
        check("w_addr", 32'(mem_addr), 4);
        check("w_we", 32'(mem_we), 32'hF);
        check("w_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("w_m0_ready", 32'(m0_ready), 1);
        check("w_m0_rdata", m0_rdata, 0);
        clr(0);
        tick();

        // Byte write then unaligned readback.
        set_req(1, 32'h20, 32'h0000_AB00, 4'h2);
        tick();
        check("b_we", 32'(mem_we), 32'h2);
        check("b_addr", 32'(mem_addr), 8);
        tick();
        check("b_m1_ready", 32'(m1_ready), 1);
        clr(1);
        tick();
        set_req(1, 32'h23, 0, 4'h0);
        tick();
        check("b_rd_addr", 32'(mem_addr), 8);
        tick();
        check("b_rdata", m1_rdata, (init_word(8) & 32'hFFFF_00FF) | 32'h0000_AB00);
        clr(1);
        tick();

        // Window edges.
        set_req(0, 32'h1000, 0, 4'h0);
        tick();
        check("oob_rd_en", 32'(mem_en), 0);
        tick();
        check("oob_rd_ready", 32'(m0_ready), 1);
        check("oob_rd_rdata", m0_rdata, 0);
        clr(0);
        tick();
        set_req(0, 32'h1004, 32'hFFFF_FFFF, 4'hF);
        tick();
        check("oob_wr_en", 32'(mem_en), 0);
        check("oob_wr_we", 32'(mem_we), 0);
        tick();
        check("oob_wr_ready", 32'(m0_ready), 1);
        clr(0);
        tick();
        set_req(1, 32'hFFC, 0, 4'h0);
        tick();
        check("top_addr", 32'(mem_addr), 1023);
        tick();
        check("top_rdata", m1_rdata, init_word(1023));
        clr(1);
        tick();

        // Valid dropped after the grant still completes.
        set_req(0, 32'h10, 0, 4'h0);
        tick();
        clr(0);
        tick();
        check("drop_ready", 32'(m0_ready), 1);
        check("drop_rdata", m0_rdata, 32'hDEAD_BEEF);
        tick();

        // m1 holds valid, m0 asks once: grants alternate.
        set_req(1, 32'h30, 0, 4'h0);
        tick();
        set_req(0, 32'h34, 0, 4'h0);
        order.delete();
        for (int i = 0; i < 12; i++) begin
            if (i == 9) clr(1);
            tick();
            if (m1_ready) order.push_back(1);
            if (m0_ready) begin order.push_back(0); clr(0); end
        end
        check("rr_count_ge3", 32'(order.size() >= 3), 1);
        if (order.size() >= 3) begin
            check("rr_first", 32'(order[0]), 1);
            check("rr_second", 32'(order[1]), 0);
            check("rr_third", 32'(order[2]), 1);
        end

        // Reset during ACCESS discards the access.
        set_req(1, 32'h20, 0, 4'h0);
        tick();
        check("rst_acc_en", 32'(mem_en), 1);
        assert_reset();
        check("rst_async_en", 32'(mem_en), 0);
        clr(1);
        tick(); tick();
        reset_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick();
            if (m0_ready || m1_ready) cnt++;
        end
        check("rst_no_ready", 32'(cnt), 0);
        set_req(0, 32'h10, 0, 4'h0);
        tick(); tick();
        check("rst_after_ready", 32'(m0_ready), 1);
        check("rst_after_rdata", m0_rdata, 32'hDEAD_BEEF);
        clr(0);
        tick();

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                assert_reset();
                clr(0); clr(1);
                tick();
                reset_n = 1'b1;
            end
            random_drive();
            tick();
        end
        clr(0); clr(1);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
